arb_mux_4_1: RTL
================

// Module: arb_mux_4_1
//
// PURPOSE
//   Shares one 4:1 data mux output between four valid/ready requesters.
//   A round-robin arbiter picks one requester per transfer and loads that
//   requester's data into a single output register (one-entry pipeline).
//   The block sits between four producers and one downstream consumer.
//
// PARAMETERS
//   W        4   data width per requester and of out_data
//
// PORTS
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous reset, active-high
//   req_valid  in   4     bit i: requester i has data
//   req_data   in   4*W   requester i data at [i*W +: W]
//   req_ready  out  4     bit i: requester i data taken this cycle
//   out_valid  out  1     output register holds a valid item
//   out_data   out  W     registered data of granted requester
//   out_src    out  2     index of requester that produced out_data
//   out_ready  in   1     consumer accepts out_data this cycle
//
// BEHAVIOUR
//   - Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, ptr=0.
//     req_ready=0 while rst=1. Reset mid-transfer drops the held item.
//   - load = !out_valid || out_ready (combinational).
//   - grant: the first i with req_valid[i]=1, searching ptr, ptr+1, ...
//     with mod-4 wrap (3 -> 0). If no req_valid bit is set, there is no grant.
//   - req_ready[i] = load && grant exists && grant==i. At most one bit is set.
//     Combinational path from req_valid/out_ready to req_ready.
//   - On a clock edge with load=1:
//       grant exists: out_data<=req_data[grant], out_src<=grant,
//                     out_valid<=1, ptr<=grant+1 (mod 4).
//       no grant:     out_valid<=0; out_data, out_src and ptr hold.
//   - With load=0 (out_valid=1, out_ready=0), out_valid/out_data/out_src hold
//     stable and ptr holds.
//   - Latency: 1 cycle from req handshake to out_valid. Throughput is one
//     item per cycle: out_ready=1 and a new grant in the same cycle gives a
//     back-to-back transfer with no bubble.
//   - FSM (implicit in out_valid): EMPTY -(grant)-> FULL;
//     FULL -(out_ready && !grant)-> EMPTY; FULL -(out_ready && grant)-> FULL;
//     FULL -(!out_ready)-> FULL.
//   - Requesters must hold req_valid/req_data until req_ready. The block
//     never grants a requester whose req_valid=0.
//
// CONFIGURATION
//   ARB_MUX_FIXED_PRIO_EN
//     defined:   fixed priority, requester 0 highest and requester 3 lowest.
//                ptr is removed (treated as constant 0).
//     undefined: round-robin as described above (default).
//   All other behaviour is identical in both builds.
//
// STRUCTURE
//   - Package arb_mux_pkg: localparam N_SRC=4; typedef logic [1:0] src_idx_t
//     (used by ptr, grant and out_src).
//   - Sub-module rr_pick_4: combinational. Inputs: 4-bit req, 2-bit ptr.
//     Outputs: any (a grant exists) and idx (src_idx_t).
//     Rotate-and-priority-encode.
//   - Top level holds ptr, the output register and the data mux.
//
// TESTING
//   1 Reset: rst=1 with req_valid=4'hF -> out_valid=0, req_ready=0,
//     out_data=0. Release rst, out_ready=1 -> first grant is src 0.
//   2 Round-robin: all valid, data {d3..d0}={d,c,b,a}, out_ready=1 ->
//     out_data a,b,c,d,a on successive cycles; out_src 0,1,2,3,0;
//     out_valid stays 1 with no bubble.
//   3 Backpressure: item b held with out_ready=0 for 3 cycles ->
//     out_data=b and out_src=1 stable; req_ready=0; ptr not advanced.
//     Next grant after release is src 2.
//   4 Sparse/wrap: ptr=3, only req_valid[1]=1 (data 7) -> grant src 1,
//     out_data=7, ptr becomes 2. With no requests and out_ready=1 ->
//     out_valid falls to 0.
//   5 Async reset mid-transfer: out_valid=1 holding 'hc, rst pulsed between
//     clock edges -> out_valid=0 immediately. Next grant starts from src 0.
//   6 ARB_MUX_FIXED_PRIO_EN build: all valid, out_ready=1 -> out_src=0 every
//     cycle. Drop req_valid[0] -> out_src=1.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared types for the 4-requester arbitrated output mux.
// Optional build macro ARB_MUX_FIXED_PRIO_EN is consumed by arb_mux_4_1.
package arb_mux_pkg;
  localparam int N_SRC = 4;

  typedef logic [1:0] src_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick_4.sv
// Rotating priority picker: the first set req bit at or after ptr, wrapping 3 -> 0.
module rr_pick_4
  import arb_mux_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         ptr,
  output logic             any,
  output src_idx_t         idx
);

  logic [N_SRC-1:0] w_rot;

  always_comb begin
    w_rot = N_SRC'({req, req} >> ptr);
    any   = |req;
    idx   = ptr;
    // Descending scan so the lowest rotated position (closest to ptr) wins.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) idx = ptr + src_idx_t'(k);
    end
  end

endmodule

// File: rtl/arb_mux_4_1.sv
// Four valid/ready requesters arbitrated into one registered output slot.
// Define ARB_MUX_FIXED_PRIO_EN for fixed priority (src 0 highest); default is round-robin.
module arb_mux_4_1
  import arb_mux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   req_valid,
  input  logic [N_SRC*W-1:0] req_data,
  output logic [N_SRC-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output src_idx_t           out_src,
  input  logic               out_ready
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [W-1:0]            r_data;
  src_idx_t                r_src;
  src_idx_t                w_ptr;
  logic                    w_load;
  logic                    w_any;
  src_idx_t                w_idx;
  logic [N_SRC-1:0][W-1:0] w_data_arr;

  assign w_data_arr = req_data;

  rr_pick_4 u_pick (
    .req (req_valid),
    .ptr (w_ptr),
    .any (w_any),
    .idx (w_idx)
  );

`ifdef ARB_MUX_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  src_idx_t r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_ptr <= '0;
    else if (w_load && w_any) r_ptr <= w_idx + src_idx_t'(1);
  end

  assign w_ptr = r_ptr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // The slot can take a new item when empty or when its current item leaves this cycle.
  always_comb begin
    w_load      = (r_state == ST_EMPTY) || out_ready;
    w_state_nxt = r_state;
    if (w_load) w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_src  <= '0;
    end else if (w_load && w_any) begin
      r_data <= w_data_arr[w_idx];
      r_src  <= w_idx;
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && w_load && w_any) req_ready[w_idx] = 1'b1;
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule
